// File: rtl/unet_fsm_3_1_ctrl.sv
// Sequencer and datapath for one 3-tap zero-padded 1-D convolution layer.
// Loads weights, bias and samples from the host, computes one output per cycle, then streams results.
module unet_fsm_3_1_ctrl #(
    parameter int N_PIX   = 8,
    parameter bit RELU_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        unet_enpulse,
    input  logic [31:0] data_in,
    output logic [2:0]  ctrl,
    output logic        busy,
    output logic [31:0] data_out
);

    localparam int IW = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int CW = (IW > 2) ? IW : 2;
    localparam logic [CW-1:0] LAST_W   = CW'(3);
    localparam logic [CW-1:0] LAST_PIX = CW'(N_PIX - 1);

    localparam logic [2:0] CTRL_CALC  = 3'd0;
    localparam logic [2:0] CTRL_SENDW = 3'd1;
    localparam logic [2:0] CTRL_SENDD = 3'd2;
    localparam logic [2:0] CTRL_READY = 3'd3;
    localparam logic [2:0] CTRL_IDLE  = 3'd4;

    localparam logic signed [34:0] ACC_MAX = 35'sd2147483647;
    localparam logic signed [34:0] ACC_MIN = -35'sd2147483648;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_D,
        S_CALC,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic            busy_q, busy_d;
    logic [31:0]     dout_q, dout_d;

    logic signed [15:0] w_q [3];
    logic signed [31:0] bias_q;
    logic signed [15:0] x_q [N_PIX];
    logic signed [31:0] y_q [N_PIX];

    logic signed [15:0] xPrev, xCur, xNext;
    logic signed [31:0] p0, p1, p2;
    logic signed [34:0] acc;
    logic signed [31:0] ySat, yAct;

    function automatic logic signed [31:0] mul16(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
        logic signed [31:0] ae, be;
        ae = {{16{a[15]}}, a};
        be = {{16{b[15]}}, b};
        return ae * be;
    endfunction

    // Output i of the current CALC cycle; neighbours outside the buffer read as zero.
    always_comb begin
        xPrev = '0;
        xNext = '0;
        xCur  = x_q[IW'(cnt_q)];
        if (cnt_q != '0)
            xPrev = x_q[IW'(cnt_q - CW'(1))];
        if (cnt_q != LAST_PIX)
            xNext = x_q[IW'(cnt_q + CW'(1))];
        p0  = mul16(w_q[0], xPrev);
        p1  = mul16(w_q[1], xCur);
        p2  = mul16(w_q[2], xNext);
        acc = {{3{bias_q[31]}}, bias_q} + {{3{p0[31]}}, p0}
            + {{3{p1[31]}}, p1} + {{3{p2[31]}}, p2};
        if (acc > ACC_MAX)
            ySat = 32'sh7FFF_FFFF;
        else if (acc < ACC_MIN)
            ySat = 32'sh8000_0000;
        else
            ySat = acc[31:0];
        yAct = (RELU_EN && ySat[31]) ? 32'sd0 : ySat;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (unet_enpulse) begin
                    state_d = S_LOAD_W;
                    cnt_d   = '0;
                end
            end
            S_LOAD_W: begin
                if (cnt_q == LAST_W) begin
                    state_d = S_LOAD_D;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD_D, S_CALC, S_OUT: begin
                if (cnt_q == LAST_PIX) begin
                    cnt_d = '0;
                    case (state_q)
                        S_LOAD_D: state_d = S_CALC;
                        S_CALC:   state_d = S_OUT;
                        default:  state_d = S_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are derived from the next state so they register alongside it.
        case (state_d)
            S_LOAD_W: ctrl_d = CTRL_SENDW;
            S_LOAD_D: ctrl_d = CTRL_SENDD;
            S_CALC:   ctrl_d = CTRL_CALC;
            S_OUT:    ctrl_d = CTRL_READY;
            default:  ctrl_d = CTRL_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        dout_d = (state_d == S_OUT) ? y_q[IW'(cnt_d)] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= CTRL_IDLE;
            busy_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++)
                w_q[i] <= '0;
            bias_q <= '0;
            for (int i = 0; i < N_PIX; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_LOAD_W: begin
                    if (cnt_q == CW'(0))      w_q[0] <= data_in[15:0];
                    else if (cnt_q == CW'(1)) w_q[1] <= data_in[15:0];
                    else if (cnt_q == CW'(2)) w_q[2] <= data_in[15:0];
                    else                      bias_q <= data_in;
                end
                S_LOAD_D: x_q[IW'(cnt_q)] <= data_in[15:0];
                S_CALC:   y_q[IW'(cnt_q)] <= yAct;
                default: ;
            endcase
        end
    end

    assign ctrl     = ctrl_q;
    assign busy     = busy_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_unet_fsm_3_1_ctrl.sv
// Directed testbench for unet_fsm_3_1_ctrl: two instances, ReLU on and off, share all inputs.
module tb_unet_fsm_3_1_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        unet_enpulse;
    logic [31:0] data_in;
    logic [2:0]  ctrl, ctrlNr;
    logic        busy, busyNr;
    logic [31:0] dataOut, dataOutNr;

    int errors = 0;
    int checks = 0;

    logic [15:0] xVec [8];
    logic [2:0]  ctrlLog [30];
    logic        busyLog [30];
    logic [31:0] dLog [30];
    logic [31:0] dNrLog [30];
    bit          pulseAt [30];

    always #5 clk = ~clk;

    unet_fsm_3_1_ctrl #(.N_PIX(8), .RELU_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .unet_enpulse(unet_enpulse), .data_in(data_in),
        .ctrl(ctrl), .busy(busy), .data_out(dataOut)
    );

    unet_fsm_3_1_ctrl #(.N_PIX(8), .RELU_EN(1'b0)) dutNr (
        .clk(clk), .rst_n(rst_n), .unet_enpulse(unet_enpulse), .data_in(data_in),
        .ctrl(ctrlNr), .busy(busyNr), .data_out(dataOutNr)
    );

    // Runs one full job from IDLE; log index c is the cycle after the start edge.
    task automatic applyStimulus(input logic [15:0] w0, input logic [15:0] w1,
                                 input logic [15:0] w2, input logic [31:0] bias);
        unet_enpulse = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 30; c++) begin
            ctrlLog[c] = ctrl;
            busyLog[c] = busy;
            dLog[c]    = dataOut;
            dNrLog[c]  = dataOutNr;
            unet_enpulse = pulseAt[c];
            if (c == 0)      data_in = {16'hA5A5, w0};
            else if (c == 1) data_in = {16'h5A5A, w1};
            else if (c == 2) data_in = {16'h1234, w2};
            else if (c == 3) data_in = bias;
            else if (c < 12) data_in = {16'hBEEF, xVec[c-4]};
            else             data_in = 32'hDEAD_0000 + 32'(c);
            @(posedge clk); #1;
        end
        unet_enpulse = 1'b0;
        for (int c = 0; c < 30; c++)
            pulseAt[c] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        unet_enpulse = 1'b1;
        data_in = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ctrl !== 3'd4) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %0d expected 4", ctrl);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy);
        end
        checks++;
        if (dataOut !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_data: got %0h expected 0", dataOut);
        end
        rst_n = 1'b0;
        unet_enpulse = 1'b0;
        data_in = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ctrl !== 3'd4 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle_%0d: got ctrl=%0d busy=%0b expected ctrl=4 busy=0", k, ctrl, busy);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] yExp [8] = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd23};
        logic [2:0] expCtrl;
        for (int k = 0; k < 8; k++) xVec[k] = 16'(k + 1);
        applyStimulus(16'd1, 16'd2, 16'd1, 32'd0);
        for (int c = 0; c < 30; c++) begin
            expCtrl = (c < 4) ? 3'd1 : (c < 12) ? 3'd2 : (c < 20) ? 3'd0 : (c < 28) ? 3'd3 : 3'd4;
            checks++;
            if (ctrlLog[c] !== expCtrl || busyLog[c] !== (c < 28)) begin
                errors++;
                $display("[TB] FAIL basic_seq_c%0d: got ctrl=%0d busy=%0b expected ctrl=%0d busy=%0b",
                         c, ctrlLog[c], busyLog[c], expCtrl, (c < 28));
            end
            checks++;
            if (dLog[c] !== ((c >= 20 && c < 28) ? yExp[c-20] : 32'd0)) begin
                errors++;
                $display("[TB] FAIL basic_data_c%0d: got %0h expected %0h", c, dLog[c],
                         (c >= 20 && c < 28) ? yExp[c-20] : 32'd0);
            end
        end
    endtask

    task automatic test_bias_signed();
        logic [31:0] yExp [8] = '{32'd83, 32'd123, 32'd75, 32'd110, 32'd115, 32'd84, 32'd97, 32'd120};
        xVec = '{16'd5, 16'hFFFE, 16'd7, 16'd0, 16'hFFFC, 16'd3, 16'd1, 16'hFFFA};
        applyStimulus(16'd2, 16'hFFFD, 16'd1, 32'd100);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dLog[20+k] !== yExp[k] || dNrLog[20+k] !== yExp[k]) begin
                errors++;
                $display("[TB] FAIL bias_y%0d: got relu=%0h norelu=%0h expected %0h",
                         k, dLog[20+k], dNrLog[20+k], yExp[k]);
            end
        end
    endtask

    task automatic test_relu();
        for (int k = 0; k < 8; k++) xVec[k] = 16'(k + 1);
        applyStimulus(16'hFFFF, 16'd0, 16'd0, 32'd0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dLog[20+k] !== 32'd0) begin
                errors++; $display("[TB] FAIL relu_on_y%0d: got %0h expected 0", k, dLog[20+k]);
            end
            checks++;
            if (dNrLog[20+k] !== 32'(-k)) begin
                errors++; $display("[TB] FAIL relu_off_y%0d: got %0h expected %0h", k, dNrLog[20+k], 32'(-k));
            end
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 8; k++) xVec[k] = 16'h7FFF;
        applyStimulus(16'h7FFF, 16'h7FFF, 16'h7FFF, 32'h7FFF_FFFF);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dLog[20+k] !== 32'h7FFF_FFFF || dNrLog[20+k] !== 32'h7FFF_FFFF) begin
                errors++;
                $display("[TB] FAIL sat_pos_y%0d: got relu=%0h norelu=%0h expected 7fffffff",
                         k, dLog[20+k], dNrLog[20+k]);
            end
        end
        applyStimulus(16'h8000, 16'h8000, 16'h8000, 32'h8000_0000);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dNrLog[20+k] !== 32'h8000_0000 || dLog[20+k] !== 32'd0) begin
                errors++;
                $display("[TB] FAIL sat_neg_y%0d: got norelu=%0h relu=%0h expected 80000000 and 0",
                         k, dNrLog[20+k], dLog[20+k]);
            end
        end
    endtask

    task automatic test_pulse_while_busy();
        int busyCount;
        logic [2:0] expCtrl;
        for (int k = 0; k < 8; k++) xVec[k] = 16'(k + 1);
        pulseAt[5]  = 1'b1;
        pulseAt[14] = 1'b1;
        pulseAt[27] = 1'b1;
        applyStimulus(16'd1, 16'd2, 16'd1, 32'd0);
        busyCount = 0;
        for (int c = 0; c < 30; c++) begin
            if (busyLog[c] === 1'b1) busyCount++;
            expCtrl = (c < 4) ? 3'd1 : (c < 12) ? 3'd2 : (c < 20) ? 3'd0 : (c < 28) ? 3'd3 : 3'd4;
            checks++;
            if (ctrlLog[c] !== expCtrl) begin
                errors++;
                $display("[TB] FAIL pulse_seq_c%0d: got ctrl=%0d expected %0d", c, ctrlLog[c], expCtrl);
            end
        end
        checks++;
        if (busyCount != 28) begin
            errors++; $display("[TB] FAIL pulse_busy_len: got %0d expected 28", busyCount);
        end
        checks++;
        if (dLog[27] !== 32'd23) begin
            errors++; $display("[TB] FAIL pulse_last_y: got %0h expected 17", dLog[27]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] yExp [8] = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd23};
        unet_enpulse = 1'b1;
        @(posedge clk); #1;
        unet_enpulse = 1'b0;
        for (int c = 0; c < 6; c++) begin
            data_in = 32'(c + 9);
            @(posedge clk); #1;
        end
        checks++;
        if (ctrl !== 3'd2) begin
            errors++; $display("[TB] FAIL midrst_pre_ctrl: got %0d expected 2", ctrl);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        checks++;
        if (ctrl !== 3'd4 || busy !== 1'b0 || dataOut !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_state: got ctrl=%0d busy=%0b data=%0h expected ctrl=4 busy=0 data=0",
                     ctrl, busy, dataOut);
        end
        for (int k = 0; k < 8; k++) xVec[k] = 16'(k + 1);
        applyStimulus(16'd1, 16'd2, 16'd1, 32'd0);
        checks++;
        if (ctrlLog[0] !== 3'd1) begin
            errors++; $display("[TB] FAIL midrst_restart: got ctrl=%0d expected 1", ctrlLog[0]);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (dLog[20+k] !== yExp[k]) begin
                errors++; $display("[TB] FAIL midrst_y%0d: got %0h expected %0h", k, dLog[20+k], yExp[k]);
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 30; c++) pulseAt[c] = 1'b0;
        for (int k = 0; k < 8; k++) xVec[k] = '0;
        test_reset();
        test_basic();
        test_bias_signed();
        test_relu();
        test_saturation();
        test_pulse_while_busy();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
